// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Each stage resolves a slice of lookahead groups and registers the carry onward.
module cla_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n
);

  localparam int NG   = WIDTH / GROUP;
  localparam int GPS  = NG / STAGES;
  localparam int LAST = STAGES - 1;
  localparam int NP   = (STAGES > 1) ? STAGES - 1 : 1;

  // inter-stage entries: operands, partial sum, carry into next slice
  logic [NP-1:0]            pv;
  logic [NP-1:0][WIDTH-1:0] pa;
  logic [NP-1:0][WIDTH-1:0] pb;
  logic [NP-1:0][WIDTH-1:0] ps;
  logic [NP-1:0]            pc;

  // final stage entry
  logic             ov;
  logic [WIDTH-1:0] osum;
  logic             oc;
  logic             ovf;
  logic             oz;
  logic             on;

  // stage inputs and results
  logic [STAGES-1:0][WIDTH-1:0] xa;
  logic [STAGES-1:0][WIDTH-1:0] xb;
  logic [STAGES-1:0][WIDTH-1:0] xs;
  logic [STAGES-1:0]            xc;
  logic [STAGES-1:0]            xv;
  logic [STAGES-1:0][WIDTH-1:0] ns;
  logic [STAGES-1:0]            nc;
  logic                         nvf;
  logic                         nz;
  logic                         nn;
  logic [STAGES-1:0]            ld;

  logic [GROUP-1:0] gg;
  logic [GROUP-1:0] pp;
  logic [GROUP:0]   cv;
  logic             cc;
  logic             cm;
  int               base;

  // all group carries as flat sums of products over g/p
  function automatic logic [GROUP:0] gcarry(
    input logic [GROUP-1:0] g,
    input logic [GROUP-1:0] p,
    input logic             ci
  );
    logic [GROUP:0] c;
    logic           t;
    c    = '0;
    c[0] = ci;
    for (int j = 1; j <= GROUP; j++) begin
      for (int i = 0; i < j; i++) begin
        t = g[i];
        for (int m = i + 1; m < j; m++) t = t & p[m];
        c[j] = c[j] | t;
      end
      t = ci;
      for (int m = 0; m < j; m++) t = t & p[m];
      c[j] = c[j] | t;
    end
    return c;
  endfunction

  // route each stage's source entry: stage 0 takes prepared operands
  always_comb begin
    xa    = '0;
    xb    = '0;
    xs    = '0;
    xc    = '0;
    xv    = '0;
    xa[0] = in_a;
    xb[0] = in_sub ? ~in_b : in_b;
    xc[0] = in_sub ^ in_cin;
    xv[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      xa[k] = pa[k-1];
      xb[k] = pb[k-1];
      xs[k] = ps[k-1];
      xc[k] = pc[k-1];
      xv[k] = pv[k-1];
    end
  end

  // resolve each stage's slice of groups, rippling group carries
  always_comb begin
    ns   = '0;
    nc   = '0;
    gg   = '0;
    pp   = '0;
    cv   = '0;
    cc   = 1'b0;
    cm   = 1'b0;
    base = 0;
    for (int k = 0; k < STAGES; k++) begin
      ns[k] = xs[k];
      cc    = xc[k];
      for (int gi = 0; gi < GPS; gi++) begin
        base = (k * GPS + gi) * GROUP;
        gg   = xa[k][base +: GROUP] & xb[k][base +: GROUP];
        pp   = xa[k][base +: GROUP] ^ xb[k][base +: GROUP];
        cv   = gcarry(gg, pp, cc);
        ns[k][base +: GROUP] = pp ^ cv[GROUP-1:0];
        cm   = cv[GROUP-1];
        cc   = cv[GROUP];
      end
      nc[k] = cc;
    end
    nvf = cm ^ nc[LAST];
    nz  = (ns[LAST] == '0);
    nn  = ns[LAST][WIDTH-1];
  end

  // a stage loads when empty or when its successor loads
  always_comb begin
    ld       = '0;
    ld[LAST] = !ov || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      ld[k] = !pv[k] || ld[k+1];
    end
  end

  assign in_ready = ld[0];

  // inter-stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      pa <= '0;
      pb <= '0;
      ps <= '0;
      pc <= '0;
    end else begin
      for (int k = 0; k < LAST; k++) begin
        if (ld[k]) pv[k] <= xv[k];
        if (ld[k] && xv[k]) begin
          pa[k] <= xa[k];
          pb[k] <= xb[k];
          ps[k] <= ns[k];
          pc[k] <= nc[k];
        end
      end
    end
  end

  // output register: sum and flags land together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov   <= 1'b0;
      osum <= '0;
      oc   <= 1'b0;
      ovf  <= 1'b0;
      oz   <= 1'b0;
      on   <= 1'b0;
    end else begin
      if (ld[LAST]) ov <= xv[LAST];
      if (ld[LAST] && xv[LAST]) begin
        osum <= ns[LAST];
        oc   <= nc[LAST];
        ovf  <= nvf;
        oz   <= nz;
        on   <= nn;
      end
    end
  end

  assign out_valid = ov;
  assign out_sum   = osum;
  assign out_c     = oc;
  assign out_v     = ovf;
  assign out_z     = oz;
  assign out_n     = on;

endmodule
